// File: rtl/horner_pkg.sv
// horner_pkg -- shared definitions for the Horner polynomial evaluator.
//   W_DEFAULT   : default datapath / coefficient / x width in bits
//   DEG_DEFAULT : default maximum polynomial degree (legal 1..15)
//   ADDR_W      : width of the coefficient index port
//   state_t     : evaluator FSM states IDLE / CALC / DONE
package horner_pkg;

    localparam int W_DEFAULT   = 32;
    localparam int DEG_DEFAULT = 4;
    localparam int ADDR_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/horner_mac.sv
// horner_mac -- one combinational Horner step: sum = acc*x + c (mod 2^W).
// Optional feature macro: HORNER_OVF_EN adds ovf_step_o, which is set when
// the full 2W-bit product has nonzero upper W bits or the add carries out.
// Ports:
//   acc_i      [W-1:0] running accumulator
//   x_i        [W-1:0] evaluation point
//   c_i        [W-1:0] coefficient for this step
//   sum_o      [W-1:0] low W bits of acc*x + c
//   ovf_step_o         overflow in this step (HORNER_OVF_EN builds only)
module horner_mac #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o
`ifdef HORNER_OVF_EN
    ,
    output logic         ovf_step_o
`endif
);

`ifdef HORNER_OVF_EN
    // Full-width product so the discarded upper half can be inspected.
    logic [2*W-1:0] prod;
    logic [W:0]     sum_ext;

    always_comb begin
        prod       = {{W{1'b0}}, acc_i} * {{W{1'b0}}, x_i};
        sum_ext    = {1'b0, prod[W-1:0]} + {1'b0, c_i};
        sum_o      = sum_ext[W-1:0];
        ovf_step_o = (|prod[2*W-1:W]) | sum_ext[W];
    end
`else
    // Only the low half of the product survives truncation, so nothing
    // above bit W-1 is built when overflow reporting is off.
    logic [W-1:0] prod_lo;

    always_comb begin
        prod_lo = acc_i * x_i;
        sum_o   = prod_lo + c_i;
    end
`endif

endmodule

// File: rtl/horner_eval.sv
// horner_eval -- evaluates p(x) = sum c[i]*x^i, i = 0..DEG, modulo 2^W using
// Horner's rule, one multiply-accumulate per clock.
// Optional feature macro: HORNER_OVF_EN enables the sticky overflow flag;
// without it ovf is tied to 0.
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   coef_we             coefficient write strobe (honoured only in IDLE)
//   coef_addr  [3:0]    coefficient index; indices above DEG are ignored
//   coef_wdata [W-1:0]  coefficient value
//   in_valid / in_ready request handshake, x sampled on accept
//   x          [W-1:0]  evaluation point
//   out_valid/out_ready result handshake
//   z          [W-1:0]  result, held while out_valid
//   ovf                 unsigned overflow flag for z
module horner_eval
    import horner_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int DEG = DEG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [W-1:0]      coef_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      z,
    output logic              ovf
);

    state_t              state_q, state_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [W-1:0]        x_q, x_d;
    logic [ADDR_W-1:0]   k_q, k_d;

    logic [W-1:0]        c_q [DEG+1];
    logic [DEG:0]        c_we;
    logic                coef_wr_en;
    logic [W-1:0]        c_sel;
    logic [W-1:0]        mac_sum;

`ifdef HORNER_OVF_EN
    logic                ovf_q, ovf_d;
    logic                ovf_step;
`endif

    // Coefficients may only change while no evaluation is in flight.
    assign coef_wr_en = coef_we && (state_q == IDLE);

    generate
        for (genvar gi = 0; gi <= DEG; gi++) begin : g_coef_we
            assign c_we[gi] = coef_wr_en && (coef_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DEG; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= DEG; i++) begin
                if (c_we[i]) begin
                    c_q[i] <= coef_wdata;
                end
            end
        end
    end

    // Coefficient for the current step, selected by the down-counter k.
    always_comb begin
        c_sel = '0;
        for (int i = 0; i <= DEG; i++) begin
            if (k_q == ADDR_W'(i)) begin
                c_sel = c_q[i];
            end
        end
    end

    horner_mac #(
        .W (W)
    ) u_mac (
        .acc_i      (acc_q),
        .x_i        (x_q),
        .c_i        (c_sel),
        .sum_o      (mac_sum)
`ifdef HORNER_OVF_EN
        ,
        .ovf_step_o (ovf_step)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            k_q     <= '0;
`ifdef HORNER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            k_q     <= k_d;
`ifdef HORNER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        k_d     = k_q;
`ifdef HORNER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    acc_d   = c_q[DEG];
                    k_d     = ADDR_W'(DEG - 1);
`ifdef HORNER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = mac_sum;
`ifdef HORNER_OVF_EN
                ovf_d = ovf_q | ovf_step;
`endif
                // k stops at 0 once the constant term has been folded in.
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = acc_q;
`ifdef HORNER_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_horner_eval.sv
// tb_horner_eval -- self-checking bench for horner_eval (W=32, DEG=2 main
// instance, plus a DEG=4 instance). A cycle-level reference model derived
// from the polynomial definition is compared against the DUT every cycle;
// directed vectors carry hand-computed literal expectations.
// Build with or without HORNER_OVF_EN; ovf expectations follow the macro.
module tb_horner_eval;

    localparam int W   = 32;
    localparam int DEG = 2;

`ifdef HORNER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      = 1'b1;
    logic          coef_we    = 1'b0;
    logic [3:0]    coef_addr  = '0;
    logic [W-1:0]  coef_wdata = '0;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x_in       = '0;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic [W-1:0]  z;
    logic          ovf;

    logic          we4 = 1'b0;
    logic [3:0]    addr4 = '0;
    logic [W-1:0]  wd4 = '0;
    logic          iv4 = 1'b0;
    logic          ir4;
    logic [W-1:0]  x4 = '0;
    logic          ov4;
    logic          or4 = 1'b0;
    logic [W-1:0]  z4;
    logic          ovf4;

    horner_eval #(.W(W), .DEG(DEG)) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .z          (z),
        .ovf        (ovf)
    );

    horner_eval #(.W(W), .DEG(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (we4),
        .coef_addr  (addr4),
        .coef_wdata (wd4),
        .in_valid   (iv4),
        .in_ready   (ir4),
        .x          (x4),
        .out_valid  (ov4),
        .out_ready  (or4),
        .z          (z4),
        .ovf        (ovf4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_c [DEG+1];
    bit           m_live = 1'b0;
    bit           m_busy = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_z    = '0;
    bit           m_ovf  = 1'b0;
    bit           exp_valid;
    int           acc_log[$];

    // Direct power-series sum, wrapping at 2^W.
    function automatic logic [W-1:0] model_z(input logic [W-1:0] xv);
        logic [W-1:0] sum = '0;
        logic [W-1:0] pw  = 1;
        for (int i = 0; i <= DEG; i++) begin
            sum = sum + m_c[i] * pw;
            pw  = pw * xv;
        end
        return sum;
    endfunction

    // Overflow: any Horner step whose exact product exceeds W bits or whose
    // add carries out.
    function automatic bit model_ovf(input logic [W-1:0] xv);
`ifdef HORNER_OVF_EN
        logic [2*W-1:0] p;
        logic [W:0]     s;
        logic [W-1:0]   a = m_c[DEG];
        bit             o = 1'b0;
        for (int k = DEG - 1; k >= 0; k--) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, xv};
            if (p[2*W-1:W] != '0) o = 1'b1;
            s = {1'b0, p[W-1:0]} + {1'b0, m_c[k]};
            if (s[W]) o = 1'b1;
            a = s[W-1:0];
        end
        return o;
`else
        return (xv == '1) && 1'b0;
`endif
    endfunction

    // Compare, then advance the model to the state after the coming edge.
    initial forever begin
        @(negedge clk);
        exp_valid = m_busy && (m_cnt >= DEG + 1);
        if (m_live) begin
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, !m_busy);
            if (exp_valid) begin
                chk("z", z, m_z);
                chk("ovf", ovf, m_ovf);
            end
        end
        if (reset) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            for (int i = 0; i <= DEG; i++) m_c[i] = '0;
        end else if (m_live) begin
            if (m_busy) begin
                if (exp_valid && out_ready) m_busy = 1'b0;
                else m_cnt++;
            end else begin
                if (coef_we && coef_addr <= 4'(DEG)) m_c[int'(coef_addr)] = coef_wdata;
                if (in_valid) begin
                    m_z    = model_z(x_in);
                    m_ovf  = model_ovf(x_in);
                    m_busy = 1'b1;
                    m_cnt  = 1;
                    acc_log.push_back(cyc + 1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic set_coefs(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2);
        wr(4'd0, c0);
        wr(4'd1, c1);
        wr(4'd2, c2);
    endtask

    task automatic start_eval(input logic [W-1:0] xv, output int acc_cyc);
        bit got = 1'b0;
        x_in     = xv;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout x=0x%0h never accepted", xv);
        end
    endtask

    task automatic wait_result(input int acc_cyc, output logic [W-1:0] zv, output logic ov, output int lat);
        bit got = 1'b0;
        zv  = '0;
        ov  = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                zv  = z;
                ov  = ovf;
                lat = cyc + 1 - acc_cyc;   // edges from accept to transfer edge
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL result_timeout out_valid never rose");
        end
    endtask

    task automatic eval(input logic [W-1:0] xv, output logic [W-1:0] zv, output logic ov, output int lat);
        int a;
        start_eval(xv, a);
        wait_result(a, zv, ov, lat);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] zr;
    logic         ovr;
    int           lat;
    int           acyc;
    int           n0;
    bit           got4;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_z", z, 0);
        chk("reset_ovf", ovf, 1'b0);

        // c = 10 + x + x^2
        out_ready = 1'b1;
        set_coefs(32'd10, 32'd1, 32'd1);
        eval(32'd1, zr, ovr, lat);
        chk("x1_z", zr, 32'd12);
        chk("x1_latency", lat, DEG + 1);
        chk("x1_ovf", ovr, 1'b0);

        // Backpressure: result must sit unchanged until out_ready.
        out_ready = 1'b0;
        start_eval(32'd2, acyc);
        wait_result(acyc, zr, ovr, lat);
        chk("x2_z", zr, 32'd16);
        repeat (5) tick();
        chk("held_z", z, 32'd16);
        chk("held_out_valid", out_valid, 1'b1);
        chk("held_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);

        // Write during CALC is dropped, as is an out-of-range index.
        start_eval(32'd2, acyc);
        wr(4'd1, 32'd50);
        wait_result(acyc, zr, ovr, lat);
        tick();
        wr(4'd3, 32'd99);
        eval(32'd2, zr, ovr, lat);
        chk("dropped_wr_z", zr, 32'd16);

        // Product overflow with zero result.
        set_coefs(32'd0, 32'd0, 32'h0001_0000);
        eval(32'h0001_0000, zr, ovr, lat);
        chk("bigx_z", zr, 32'd0);
        chk("bigx_ovf", ovr, OVF_ON);

        // Carry out of the final add.
        set_coefs(32'hFFFF_FFFF, 32'd1, 32'd0);
        eval(32'd1, zr, ovr, lat);
        chk("carry_z", zr, 32'd0);
        chk("carry_ovf", ovr, OVF_ON);

        // x = 0 returns c0; x = -1 alternates signs mod 2^32.
        set_coefs(32'd3, 32'd2, 32'd1);
        eval(32'd0, zr, ovr, lat);
        chk("x0_z", zr, 32'd3);
        chk("x0_ovf", ovr, 1'b0);
        set_coefs(32'd1, 32'd2, 32'd3);
        eval(32'hFFFF_FFFF, zr, ovr, lat);
        chk("xneg_z", zr, 32'd2);
        chk("xneg_ovf", ovr, OVF_ON);

        // Back-to-back requests with in_valid held: one accept per DEG+2.
        n0       = acc_log.size();
        x_in     = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && acc_log.size() < n0 + 3; i++) tick();
        in_valid = 1'b0;
        if (acc_log.size() >= n0 + 3) begin
            chk("throughput_1", acc_log[n0+1] - acc_log[n0], DEG + 2);
            chk("throughput_2", acc_log[n0+2] - acc_log[n0+1], DEG + 2);
        end else begin
            checks++;
            failures++;
            $display("FAIL throughput_timeout accepts=%0d required=3", acc_log.size() - n0);
        end
        repeat (DEG + 3) tick();

        // Reset during the second CALC cycle abandons the evaluation.
        set_coefs(32'd10, 32'd1, 32'd1);
        start_eval(32'd1, acyc);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_out_valid", out_valid, 1'b0);
            chk("abort_z", z, 0);
            chk("abort_ovf", ovf, 1'b0);
            tick();
        end
        chk("abort_in_ready", in_ready, 1'b1);
        eval(32'd5, zr, ovr, lat);
        chk("abort_coef_cleared_z", zr, 32'd0);
        set_coefs(32'd3, 32'd2, 32'd1);
        eval(32'd4, zr, ovr, lat);
        chk("after_abort_z", zr, 32'd27);
        chk("after_abort_latency", lat, DEG + 1);

        // DEG=4 instance: all-ones coefficients at x=3 -> 121.
        for (int i = 0; i <= 4; i++) begin
            we4   = 1'b1;
            addr4 = 4'(i);
            wd4   = 32'd1;
            tick();
        end
        we4 = 1'b0;
        or4 = 1'b1;
        x4  = 32'd3;
        chk("deg4_in_ready", ir4, 1'b1);
        iv4 = 1'b1;
        tick();
        iv4  = 1'b0;
        acyc = cyc;
        got4 = 1'b0;
        for (int i = 0; i < 30 && !got4; i++) begin
            @(negedge clk);
            if (ov4) begin
                got4 = 1'b1;
                chk("deg4_z", z4, 32'd121);
                chk("deg4_latency", cyc + 1 - acyc, 5);
                chk("deg4_ovf", ovf4, 1'b0);
            end
        end
        if (!got4) begin
            checks++;
            failures++;
            $display("FAIL deg4_timeout out_valid never rose");
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
